change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Dispenses change through two coin hoppers (10rs and 5rs) on behalf of the vending
//  controller. Takes a change amount over a valid/ready request and pays it out greedily,
//  10rs coins first. Fires one timed eject pulse per coin and waits for the hopper's
//  coin-sensed pulse before the next coin. Reports done or err with a 1-cycle pulse.
// PARAMETERS
//  AMT_W       4   width of req_amt; amount counted in 5rs units (max 15 = 75rs)
//  PULSE_CYC   4   cycles an eject output stays high per coin (>=1)
//  GAP_CYC     2   idle cycles after coin_seen before the next eject or done (>=1)
//  TIMEOUT_CYC 64  cycles from eject rise without coin_seen before err
//  INV_W       8   hopper inventory counter width (CHANGE_INVENTORY_EN only)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  req_valid  in   1      change request valid
//  req_amt    in   AMT_W  change amount in 5rs units
//  req_ready  out  1      high only in IDLE
//  eject10    out  1      10rs hopper eject pulse
//  eject5     out  1      5rs hopper eject pulse
//  coin_seen  in   1      1-cycle pulse from the exit sensor: one coin left the active hopper
//  busy       out  1      high in every state except IDLE
//  done       out  1      1-cycle pulse: full amount paid
//  err        out  1      1-cycle pulse: payout abandoned
// BEHAVIOUR
//  - Reset (async): state=IDLE. All outputs 0 except req_ready=1. remaining=0. Timers=0.
//  - States: IDLE, SELECT, PULSE, WAIT_ACK, GAP, FINISH, FAIL.
//  - IDLE: on req_valid&&req_ready, latch remaining=req_amt -> SELECT. req_ready=0 from the next cycle.
//  - SELECT (1 cycle): if remaining==0 -> FINISH. Else if remaining>=2 and 10rs usable,
//    sel=10. Else if 5rs usable, sel=5. Else -> FAIL. Then -> PULSE.
//  - PULSE: drive the selected eject for exactly PULSE_CYC cycles, then -> WAIT_ACK.
//    Eject rises 2 cycles after the accept edge.
//  - coin_seen in PULSE or WAIT_ACK: remaining -= (sel==10 ? 2 : 1); eject drops the next
//    cycle if still high; -> GAP. The timeout counter starts at eject rise and covers
//    PULSE and WAIT_ACK together. If it reaches TIMEOUT_CYC -> FAIL.
//  - GAP: wait GAP_CYC cycles -> SELECT.
//  - FINISH: done=1 for 1 cycle -> IDLE. FAIL: err=1 for 1 cycle; clear remaining -> IDLE.
//  - coin_seen in IDLE, SELECT, GAP, FINISH or FAIL is ignored (no count change).
//  - A second coin_seen in the same coin window is ignored.
//  - Never drive eject10 and eject5 high in the same cycle.
//  - req_amt=0: accepted; done pulses 2 cycles after accept; no eject.
//  - Arithmetic: remaining is AMT_W bits. The decrement never underflows because sel=10
//    requires remaining>=2.
//  - rst asserted mid-payout: immediate return to IDLE. Eject drops at once. No done/err.
// CONFIGURATION
//  CHANGE_INVENTORY_EN defined:
//    - Extra ports: inv_load (in 1), inv10_in (in INV_W), inv5_in (in INV_W),
//      empty10 (out 1), empty5 (out 1).
//    - inv_load loads both counters and takes priority over decrements in the same cycle.
//    - The matching counter decrements on each counted coin_seen and saturates at 0.
//    - emptyN is high when its counter==0. A hopper is usable when its counter is nonzero.
//    - When 10rs is empty, pay with two 5rs coins. When nothing usable remains, FAIL.
//    - Counters reset to 0.
//  Not defined:
//    - No inventory ports or logic. Both hoppers are always usable.
// TESTING
//  T1 req_amt=3 with prompt coin_seen -> one eject10 pulse of 4 cycles, then one eject5
//     pulse; done once; busy low after.
//  T2 req_amt=0 -> no eject; done exactly 2 cycles after accept; req_ready back 1 the cycle after.
//  T3 req_amt=2 with no coin_seen -> err pulse 64 cycles after eject10 rise; no done; IDLE.
//  T4 rst pulsed during the second coin's PULSE -> eject5 low in the same cycle;
//     req_ready=1; no done/err.
//  T5 coin_seen pulses in IDLE and GAP, and twice in one window -> remaining
//     decremented only once per coin.
//  T6 (CHANGE_INVENTORY_EN) inv10=0, inv5=3, req_amt=2 -> two eject5 coins, done, inv5=1.
//     Then req_amt=2 -> one 5rs coin, then err; empty5=1.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 10rs/5rs change payout with timed eject pulses and coin-sensed handshake.
// Define CHANGE_INVENTORY_EN to add per-hopper inventory counters and empty flags.
module change_dispenser #(
   parameter int AMT_W       = 4,
   parameter int PULSE_CYC   = 4,
   parameter int GAP_CYC     = 2,
   parameter int TIMEOUT_CYC = 64,
   parameter int INV_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amt,
   output logic             req_ready,
   output logic             eject10,
   output logic             eject5,
   input  logic             coin_seen,
`ifdef CHANGE_INVENTORY_EN
   input  logic             inv_load,
   input  logic [INV_W-1:0] inv10_in,
   input  logic [INV_W-1:0] inv5_in,
   output logic             empty10,
   output logic             empty5,
`endif
   output logic             busy,
   output logic             done,
   output logic             err
);
   typedef enum logic [2:0] {IDLE, SELECT, PULSE, WAIT_ACK, GAP, FINISH, FAIL} state_t;
   localparam int TW = $clog2(TIMEOUT_CYC + PULSE_CYC + GAP_CYC + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] P_LAST = TW'(PULSE_CYC - 1);
   localparam logic [TW-1:0] G_LAST = TW'(GAP_CYC - 1);
   state_t state;
   logic [AMT_W-1:0] remaining;
   logic [TW-1:0] timer;
   logic sel10, use10, use5, counted;
   assign counted = coin_seen && (state == PULSE || state == WAIT_ACK);
`ifdef CHANGE_INVENTORY_EN
   logic [INV_W-1:0] inv10, inv5;
   assign use10 = inv10 != '0;
   assign use5 = inv5 != '0;
   assign empty10 = !use10;
   assign empty5 = !use5;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         inv10 <= '0;
         inv5 <= '0;
      end else if (inv_load) begin
         inv10 <= inv10_in;
         inv5 <= inv5_in;
      end else if (counted) begin
         if (sel10 && use10) inv10 <= inv10 - 1'b1;
         if (!sel10 && use5) inv5 <= inv5 - 1'b1;
      end
`else
   assign use10 = 1'b1;
   assign use5 = 1'b1;
`endif
   // one timer serves the pulse width and the ack timeout (both start at eject rise) and the gap
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         remaining <= '0;
         timer <= '0;
         sel10 <= 1'b0;
         req_ready <= 1'b1;
         busy <= 1'b0;
         eject10 <= 1'b0;
         eject5 <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         done <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE:
               if (req_valid) begin
                  remaining <= req_amt;
                  req_ready <= 1'b0;
                  busy <= 1'b1;
                  state <= SELECT;
               end
            SELECT: begin
               timer <= '0;
               if (remaining == '0) begin
                  done <= 1'b1;
                  state <= FINISH;
               end else if (remaining >= AMT_W'(2) && use10) begin
                  sel10 <= 1'b1;
                  eject10 <= 1'b1;
                  state <= PULSE;
               end else if (use5) begin
                  sel10 <= 1'b0;
                  eject5 <= 1'b1;
                  state <= PULSE;
               end else begin
                  err <= 1'b1;
                  state <= FAIL;
               end
            end
            PULSE, WAIT_ACK:
               if (coin_seen) begin
                  remaining <= remaining - (sel10 ? AMT_W'(2) : AMT_W'(1));
                  eject10 <= 1'b0;
                  eject5 <= 1'b0;
                  timer <= '0;
                  state <= GAP;
               end else if (timer == T_LAST) begin
                  eject10 <= 1'b0;
                  eject5 <= 1'b0;
                  err <= 1'b1;
                  state <= FAIL;
               end else begin
                  timer <= timer + 1'b1;
                  if (state == PULSE && timer == P_LAST) begin
                     eject10 <= 1'b0;
                     eject5 <= 1'b0;
                     state <= WAIT_ACK;
                  end
               end
            GAP:
               if (timer == G_LAST) state <= SELECT;
               else timer <= timer + 1'b1;
            FINISH, FAIL: begin
               remaining <= '0;
               req_ready <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed payouts; stimulus queues expected events, a negedge monitor pops and compares them.
module tb_change_dispenser;
   logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, coin_seen = 1'b0;
   logic [3:0] req_amt = '0;
   logic req_ready, eject10, eject5, busy, done, err;
`ifdef CHANGE_INVENTORY_EN
   logic inv_load = 1'b0, empty10, empty5;
   logic [7:0] inv10_in = '0, inv5_in = '0;
`endif
   change_dispenser dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_amt(req_amt), .req_ready(req_ready),
      .eject10(eject10), .eject5(eject5), .coin_seen(coin_seen),
`ifdef CHANGE_INVENTORY_EN
      .inv_load(inv_load), .inv10_in(inv10_in), .inv5_in(inv5_in), .empty10(empty10), .empty5(empty5),
`endif
      .busy(busy), .done(done), .err(err)
   );
   // kind: 1 eject10 rise, 2 eject5 rise, 3 done, 4 err; width only used for ejects
   typedef struct {int kind; int cyc; int width;} ev_t;
   ev_t q[$];
   int cyc = 0, passed = 0, total = 0, overlap = 0;
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end
   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
   endtask
   task automatic expect_ev(input int kind, input int c, input int width);
      q.push_back('{kind, c, width});
   endtask
   task automatic to_cycle(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic req(input int amt, output int a);
      a = cyc;
      req_valid = 1'b1;
      req_amt = 4'(amt);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask
   task automatic coin(input int c, input int n = 1);
      to_cycle(c);
      coin_seen = 1'b1;
      to_cycle(c + n);
      coin_seen = 1'b0;
   endtask
   // monitor
   initial begin
      logic p10, p5;
      int w;
      ev_t cur;
      p10 = 1'b0;
      p5 = 1'b0;
      w = 0;
      cur = '{0, 0, 0};
      forever begin
         @(negedge clk);
         if (eject10 && eject5) overlap++;
         if ((eject10 && !p10) || (eject5 && !p5) || done || err) begin
            if (q.size() == 0) begin
               total++;
               $display("FAIL unexpected_event: got e10=%0d e5=%0d done=%0d err=%0d required none (cycle %0d)",
                        eject10, eject5, done, err, cyc);
            end else begin
               cur = q.pop_front();
               chk("event_kind", (eject10 && !p10) ? 1 : (eject5 && !p5) ? 2 : done ? 3 : 4, cur.kind);
               chk("event_cycle", cyc, cur.cyc);
            end
            w = 1;
         end else if (eject10 || eject5) w++;
         if ((!eject10 && p10) || (!eject5 && p5)) chk("eject_width", w, cur.width);
         p10 = eject10;
         p5 = eject5;
      end
   end
   initial begin
      int a, b, s;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ejects", {eject10, eject5, done, err}, 0);
      rst = 1'b0;
      to_cycle(cyc + 2);
      // T1: 15rs -> one 10rs (ack in WAIT_ACK), one 5rs (ack during PULSE)
      req(3, a);
      expect_ev(1, a + 2, 4);
      expect_ev(2, a + 10, 2);
      expect_ev(3, a + 15, 0);
      coin(a + 6);
      coin(a + 11);
      to_cycle(a + 16);
      chk("t1_busy_after", busy, 0);
      chk("t1_ready_after", req_ready, 1);
      // T2: zero amount
      to_cycle(cyc + 2);
      req(0, a);
      expect_ev(3, a + 2, 0);
      to_cycle(a + 2);
      chk("t2_ready_low", req_ready, 0);
      to_cycle(a + 3);
      chk("t2_ready_back", req_ready, 1);
      // T3: no ack -> timeout
      to_cycle(cyc + 2);
      req(2, a);
      expect_ev(1, a + 2, 4);
      expect_ev(4, a + 66, 0);
      to_cycle(a + 67);
      chk("t3_ready", req_ready, 1);
      chk("t3_busy", busy, 0);
      // T4: reset during second coin's pulse
      to_cycle(cyc + 2);
      req(3, a);
      expect_ev(1, a + 2, 4);
      expect_ev(2, a + 10, 1);
      coin(a + 6);
      to_cycle(a + 11);
      rst = 1'b1;
      #1;
      chk("t4_eject5_drop", eject5, 0);
      chk("t4_ready", req_ready, 1);
      chk("t4_busy", busy, 0);
      to_cycle(a + 12);
      rst = 1'b0;
      // T5: stray coins in IDLE, GAP, FINISH and a repeated one in a window
      to_cycle(cyc + 2);
      s = cyc;
      coin(s);
      req(3, a);
      expect_ev(1, a + 2, 2);
      expect_ev(2, a + 7, 1);
      expect_ev(3, a + 11, 0);
      coin(a + 3, 3);
      coin(a + 7);
      coin(a + 11);
      to_cycle(a + 12);
      chk("t5_ready", req_ready, 1);
`ifdef CHANGE_INVENTORY_EN
      // T6: 10rs hopper empty, 5rs holds three coins
      to_cycle(cyc + 2);
      inv_load = 1'b1;
      inv10_in = 8'd0;
      inv5_in = 8'd3;
      to_cycle(cyc + 1);
      inv_load = 1'b0;
      chk("t6_empty10_loaded", empty10, 1);
      req(2, a);
      expect_ev(2, a + 2, 4);
      expect_ev(2, a + 10, 4);
      expect_ev(3, a + 18, 0);
      coin(a + 6);
      coin(a + 14);
      to_cycle(a + 19);
      chk("t6_empty10", empty10, 1);
      chk("t6_empty5_not", empty5, 0);
      to_cycle(cyc + 2);
      req(2, b);
      expect_ev(2, b + 2, 4);
      expect_ev(4, b + 10, 0);
      coin(b + 6);
      to_cycle(b + 11);
      chk("t6_empty5", empty5, 1);
      chk("t6_ready", req_ready, 1);
`endif
      to_cycle(cyc + 5);
      chk("sb_drained", q.size(), 0);
      chk("eject_overlap", overlap, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
